dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, number of 32-bit RAM words (power of two, max 4096).
REQ-002 Parameter PRESCALE, default 1, clock cycles per timer increment (>=1).
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 MemWrite_s  input  1  write strobe from the core data port.
REQ-006 addrData_s  input  16  byte address from the core data port.
REQ-007 dataWrite_s  input  32  write data from the core.
REQ-008 dataRead_s  output  32  read data to the core.
REQ-009 gpio_out  output  8  GPIO output register contents.
REQ-010 irq_timer  output  1  timer match flag, level.

Function
REQ-011 Address map, word-granular, addrData_s[1:0] ignored on all accesses:
- 0x0000..RAM_WORDS*4-1: RAM.
- 0xF000: GPIO (R/W, bits 7:0; upper bits read 0).
- 0xF004: TIMER count (R/W).
- 0xF008: COMPARE (R/W).
- 0xF00C: STATUS (bit0 match flag, write-1-to-clear; other bits read 0).
- All other addresses unmapped.
REQ-012 Reads SHALL be combinational from addrData_s with zero-cycle latency, so a single-cycle core sees data in the same cycle.
REQ-013 Writes SHALL take effect on the rising clk edge while MemWrite_s=1; a read of the same address in the same cycle SHALL return the old value.
REQ-014 RAM index SHALL be addrData_s[log2(RAM_WORDS)+1:2].
REQ-015 Unmapped reads SHALL return 0x00000000; unmapped writes SHALL have no effect.
REQ-016 Prescaler counter SHALL count 0..PRESCALE-1 and wrap; TIMER SHALL increment by 1 on each wrap.
REQ-017 TIMER SHALL wrap 0xFFFFFFFF -> 0x00000000 with no flag.
REQ-018 A TIMER write SHALL load dataWrite_s, take priority over the increment that cycle, and clear the prescaler to 0.
REQ-019 Match flag SHALL set on the edge after which TIMER equals COMPARE, i.e. when the registered TIMER == COMPARE.
REQ-020 Match detection SHALL also fire when TIMER is written to a value equal to COMPARE.
REQ-021 Match detection SHALL also fire when COMPARE is written to a value equal to TIMER.
REQ-022 Writing STATUS with bit0=1 SHALL clear the flag; if set and clear coincide, set SHALL win.
REQ-023 irq_timer SHALL equal the match flag.
REQ-024 gpio_out SHALL equal GPIO[7:0].

Reset
REQ-025 rst=0 SHALL immediately and asynchronously set the following, independent of clk:
- GPIO=0, TIMER=0, prescaler=0.
- COMPARE=0xFFFFFFFF.
- Flag=0, so irq_timer=0 and gpio_out=0.
REQ-026 RAM contents SHALL NOT be reset; a write in progress when reset asserts SHALL be discarded for registers and is don't-care for RAM.
REQ-027 After rst deasserts, TIMER SHALL begin counting on the first rising edge.

Verification
REQ-028 Write 0xDEADBEEF to 0x0010, then read 0x0010 and 0x0013 -> both return 0xDEADBEEF; read 0x0014 after writing it 0x1 -> 0x00000001.
REQ-029 Write 0x1A5 to 0xF000 -> gpio_out=0xA5 next cycle; read 0xF000=0x000000A5; read 0xE000 -> 0x00000000.
REQ-030 PRESCALE=1, write COMPARE=5 and TIMER=0 in consecutive cycles -> irq_timer rises exactly when TIMER reads 5; write STATUS=1 -> irq_timer=0.
REQ-031 Write TIMER=0xFFFFFFFE -> two edges later TIMER reads 0x00000000 and irq_timer stays 0.
REQ-032 With the flag set, hold the STATUS clear write on the cycle a new match occurs -> flag remains 1.
REQ-033 Pulse rst low mid-count with GPIO=0xFF -> gpio_out=0, TIMER=0, COMPARE=0xFFFFFFFF before the next clk edge; RAM word written earlier still reads back unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle core: word RAM plus a small
// register block (GPIO, free-running timer, compare, match status).
// Reads are purely combinational; all writes land on the rising clock edge.
module dmem_responder #(
  parameter int RAM_WORDS = 1024,
  parameter int PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite_s,
  input  logic [15:0] addrData_s,
  input  logic [31:0] dataWrite_s,
  output logic [31:0] dataRead_s,
  output logic [7:0]  gpio_out,
  output logic        irq_timer
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  // Register-block word addresses (byte address >> 2)
  localparam logic [13:0] GPIO_WORD   = 14'h3C00;
  localparam logic [13:0] TIMER_WORD  = 14'h3C01;
  localparam logic [13:0] CMP_WORD    = 14'h3C02;
  localparam logic [13:0] STATUS_WORD = 14'h3C03;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    gpio;
  logic [31:0]   timer;
  logic [31:0]   compare;
  logic [PW-1:0] pre;
  logic          flag;

  logic [31:0]   timer_next;
  logic [31:0]   compare_next;
  logic [PW-1:0] pre_next;
  logic          flag_next;
  logic          match_set;
  logic          match_clr;

  logic [13:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          ram_sel;
  logic          gpio_sel;
  logic          timer_sel;
  logic          cmp_sel;
  logic          status_sel;
  logic          unused_byte_bits;

  assign word_addr        = addrData_s[15:2];
  assign ram_idx          = addrData_s[AW+1:2];
  assign ram_sel          = ({16'h0000, addrData_s} < 32'(RAM_WORDS * 4));
  assign gpio_sel         = (word_addr == GPIO_WORD);
  assign timer_sel        = (word_addr == TIMER_WORD);
  assign cmp_sel          = (word_addr == CMP_WORD);
  assign status_sel       = (word_addr == STATUS_WORD);
  assign unused_byte_bits = &{1'b0, addrData_s[1:0]};

  assign gpio_out  = gpio;
  assign irq_timer = flag;

  // Next timer/compare/flag values; match compares the values the registers will hold after this edge
  always_comb begin
    pre_next     = pre;
    timer_next   = timer;
    compare_next = compare;
    if (MemWrite_s && timer_sel) begin
      timer_next = dataWrite_s;
      pre_next   = '0;
    end else if (pre == PRE_LAST) begin
      timer_next = timer + 32'd1;
      pre_next   = '0;
    end else begin
      pre_next = pre + 1'b1;
    end
    if (MemWrite_s && cmp_sel) begin
      compare_next = dataWrite_s;
    end
    match_set = (timer_next == compare_next);
    match_clr = MemWrite_s && status_sel && dataWrite_s[0];
    flag_next = match_set | (flag & ~match_clr);
  end

  // Register block state, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio    <= 8'h00;
      timer   <= 32'h0000_0000;
      compare <= 32'hFFFF_FFFF;
      pre     <= '0;
      flag    <= 1'b0;
    end else begin
      if (MemWrite_s && gpio_sel) begin
        gpio <= dataWrite_s[7:0];
      end
      timer   <= timer_next;
      compare <= compare_next;
      pre     <= pre_next;
      flag    <= flag_next;
    end
  end

  // RAM array; contents survive reset
  always_ff @(posedge clk) begin
    if (MemWrite_s && ram_sel) begin
      ram[ram_idx] <= dataWrite_s;
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero
  always_comb begin
    dataRead_s = 32'h0000_0000;
    if (ram_sel) begin
      dataRead_s = ram[ram_idx];
    end else if (gpio_sel) begin
      dataRead_s = {24'h000000, gpio};
    end else if (timer_sel) begin
      dataRead_s = timer;
    end else if (cmp_sel) begin
      dataRead_s = compare;
    end else if (status_sel) begin
      dataRead_s = {31'h0, flag};
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, GPIO, timer/compare/status and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  gpio;
  logic        irq;

  // second instance with a slower prescaler, left idle reading TIMER
  logic [31:0] rdata2;
  logic [7:0]  gpio2;
  logic        irq2;

  int total;
  int bad;

  dmem_responder #(.RAM_WORDS(1024), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .MemWrite_s(mem_write), .addrData_s(addr),
    .dataWrite_s(wdata), .dataRead_s(rdata), .gpio_out(gpio), .irq_timer(irq)
  );

  dmem_responder #(.RAM_WORDS(256), .PRESCALE(3)) dut_slow (
    .clk(clk), .rst(rst), .MemWrite_s(1'b0), .addrData_s(16'hF004),
    .dataWrite_s(32'h0), .dataRead_s(rdata2), .gpio_out(gpio2), .irq_timer(irq2)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input logic [15:0] a, input logic [31:0] expected, input string tag);
    addr = a;
    #1;
    checkOutput(tag, rdata, expected);
  endtask

  // one write cycle; returns 1 time unit after the capturing edge
  task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    mem_write = 1'b0;
    addr      = 16'h0000;
    wdata     = 32'h0;

    // reset state
    #12;
    checkOutput("rst_gpio_out", {24'h0, gpio}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    readCheck(16'hF004, 32'h0000_0000, "rst_timer");
    readCheck(16'hF008, 32'hFFFF_FFFF, "rst_compare");
    readCheck(16'hF00C, 32'h0000_0000, "rst_status");
    readCheck(16'hF000, 32'h0000_0000, "rst_gpio_rd");

    // timer starts on the first edge after release
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    readCheck(16'hF004, 32'h0000_0001, "timer_first_edge");
    checkOutput("slow_timer_1edge", rdata2, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    readCheck(16'hF004, 32'h0000_0003, "timer_third_edge");
    checkOutput("slow_timer_3edge", rdata2, 32'h1);

    // RAM write/read, byte offset ignored
    applyStimulus(16'h0010, 32'hDEAD_BEEF);
    readCheck(16'h0010, 32'hDEAD_BEEF, "ram_0010");
    readCheck(16'h0013, 32'hDEAD_BEEF, "ram_0013");
    applyStimulus(16'h0014, 32'h0000_0001);
    readCheck(16'h0014, 32'h0000_0001, "ram_0014");

    // read in the write cycle returns the old value
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 16'h0014;
    wdata     = 32'h0000_0022;
    #1;
    checkOutput("ram_read_old", rdata, 32'h0000_0001);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    readCheck(16'h0014, 32'h0000_0022, "ram_read_new");

    // GPIO and unmapped space
    applyStimulus(16'hF000, 32'h0000_01A5);
    checkOutput("gpio_out_a5", {24'h0, gpio}, 32'h0000_00A5);
    readCheck(16'hF000, 32'h0000_00A5, "gpio_rd");
    readCheck(16'hE000, 32'h0000_0000, "unmapped_rd");
    applyStimulus(16'hE000, 32'h0000_0123);
    readCheck(16'hE000, 32'h0000_0000, "unmapped_wr");
    applyStimulus(16'h0000, 32'h0000_0011);
    applyStimulus(16'h1000, 32'h0000_0099);
    readCheck(16'h0000, 32'h0000_0011, "ram_no_alias");

    // COMPARE=5 then TIMER=0; irq rises exactly as TIMER reaches 5
    applyStimulus(16'hF008, 32'h0000_0005);
    applyStimulus(16'hF004, 32'h0000_0000);
    checkOutput("match_irq_t0", {31'h0, irq}, 32'h0);
    readCheck(16'hF004, 32'h0000_0000, "timer_loaded");
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      readCheck(16'hF004, 32'(k), $sformatf("timer_count_%0d", k));
      checkOutput($sformatf("irq_count_%0d", k), {31'h0, irq}, (k == 5) ? 32'h1 : 32'h0);
    end
    readCheck(16'hF00C, 32'h0000_0001, "status_set");
    @(posedge clk);
    #1;
    checkOutput("irq_held", {31'h0, irq}, 32'h1);
    applyStimulus(16'hF00C, 32'h0000_0001);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

    // COMPARE written equal to the incremented TIMER
    applyStimulus(16'hF004, 32'd100);
    applyStimulus(16'hF008, 32'd101);
    checkOutput("match_on_cmp_wr", {31'h0, irq}, 32'h1);

    // set wins over clear on the same edge
    applyStimulus(16'hF008, 32'd50);
    applyStimulus(16'hF004, 32'd49);
    applyStimulus(16'hF00C, 32'h0000_0001);
    checkOutput("set_wins_irq", {31'h0, irq}, 32'h1);
    readCheck(16'hF004, 32'd50, "set_wins_timer");
    applyStimulus(16'hF00C, 32'h0000_0001);
    checkOutput("clear_after_wins", {31'h0, irq}, 32'h0);

    // TIMER written equal to COMPARE; bit0=0 status write does not clear
    applyStimulus(16'hF004, 32'd50);
    checkOutput("match_on_timer_wr", {31'h0, irq}, 32'h1);
    applyStimulus(16'hF00C, 32'h0000_0002);
    checkOutput("status_bit1_noclr", {31'h0, irq}, 32'h1);
    applyStimulus(16'hF00C, 32'h0000_0001);
    checkOutput("status_clr", {31'h0, irq}, 32'h0);

    // TIMER wrap without a flag
    applyStimulus(16'hF004, 32'hFFFF_FFFE);
    @(posedge clk);
    @(posedge clk);
    #1;
    readCheck(16'hF004, 32'h0000_0000, "timer_wrap");
    checkOutput("wrap_no_irq", {31'h0, irq}, 32'h0);

    // asynchronous reset mid-count with a GPIO write pending
    applyStimulus(16'hF000, 32'h0000_00FF);
    checkOutput("gpio_ff", {24'h0, gpio}, 32'h0000_00FF);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 16'hF000;
    wdata     = 32'h0000_0055;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_gpio", {24'h0, gpio}, 32'h0);
    checkOutput("async_irq", {31'h0, irq}, 32'h0);
    mem_write = 1'b0;
    readCheck(16'hF004, 32'h0000_0000, "async_timer");
    readCheck(16'hF008, 32'hFFFF_FFFF, "async_compare");
    mem_write = 1'b1;
    addr      = 16'hF000;
    @(posedge clk);
    #1;
    checkOutput("reset_discards_wr", {24'h0, gpio}, 32'h0);
    @(negedge clk);
    mem_write = 1'b0;
    rst       = 1'b1;
    readCheck(16'h0010, 32'hDEAD_BEEF, "ram_kept_0010");
    readCheck(16'h0014, 32'h0000_0022, "ram_kept_0014");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
